// File: rtl/mips_multicycle.sv
// mips_multicycle: multicycle MIPS core (lw/sw/R-type/addi/beq/j) sharing one ALU
// and one req/ready memory port; halts on illegal opcodes.
module mips_multicycle #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          NREGS    = 32
) (
  input  logic        iClk,
  input  logic        iReset,
  output logic        oMemReq,
  output logic        oMemWe,
  output logic [31:0] oMemAddr,
  output logic [31:0] oMemWdata,
  input  logic [31:0] iMemRdata,
  input  logic        iMemReady,
  output logic [31:0] oPC,
  output logic [3:0]  oState,
  output logic        oHalt,
  output logic        oRetire
);
  localparam int RW = $clog2(NREGS);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, ADDIEX, ADDIWB, BRANCH, JUMP, HALT
  } state_t;
  state_t        state_q, dec_d;
  logic [31:0]   pc_q, ir_q, mdr_q, alu_q, a_q, b_q;
  logic [31:0]   regs_q [NREGS];
  logic [5:0]    op, funct;
  logic [RW-1:0] rs, rt, rd, wr_idx;
  logic [31:0]   simm, alu_d, wr_data;
  logic          funct_ok, wr_en, run;
  assign op       = ir_q[31:26];
  assign funct    = ir_q[5:0];
  assign rs       = ir_q[21+:RW];
  assign rt       = ir_q[16+:RW];
  assign rd       = ir_q[11+:RW];
  assign simm     = {{16{ir_q[15]}}, ir_q[15:0]};
  assign funct_ok = funct inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
  always_comb
    alu_d = funct == 6'b100010 ? a_q - b_q :
            funct == 6'b100100 ? a_q & b_q :
            funct == 6'b100101 ? a_q | b_q :
            funct == 6'b101010 ? {31'b0, $signed(a_q) < $signed(b_q)} :
                                 a_q + b_q;
  always_comb
    dec_d = (op == 6'b100011 || op == 6'b101011) ? MEMADR :
            op == 6'b000000 ? (funct_ok ? EXEC : HALT) :
            op == 6'b001000 ? ADDIEX :
            op == 6'b000100 ? BRANCH :
            op == 6'b000010 ? JUMP : HALT;
  assign wr_en   = state_q inside {MEMWB, ALUWB, ADDIWB};
  assign wr_idx  = state_q == ALUWB ? rd : rt;
  assign wr_data = state_q == MEMWB ? mdr_q : alu_q;
  // While reset is held the state already reads FETCH, so gate the strobes off.
  assign run       = !iReset;
  assign oMemReq   = run && state_q inside {FETCH, MEMRD, MEMWR};
  assign oMemWe    = run && state_q == MEMWR;
  assign oMemAddr  = state_q == FETCH ? pc_q : alu_q;
  assign oMemWdata = b_q;
  assign oPC       = pc_q;
  assign oState    = state_q;
  assign oHalt     = state_q == HALT;
  assign oRetire   = run && (state_q inside {MEMWB, ALUWB, ADDIWB, BRANCH, JUMP} ||
                             (state_q == MEMWR && iMemReady));
  always_ff @(posedge iClk or posedge iReset)
    if (iReset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      mdr_q   <= '0;
      alu_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      if (wr_en && wr_idx != '0) regs_q[wr_idx] <= wr_data;
      case (state_q)
        FETCH:  if (iMemReady) begin
                  ir_q    <= iMemRdata;
                  pc_q    <= pc_q + 32'd4;
                  state_q <= DECODE;
                end
        DECODE: begin
                  a_q     <= regs_q[rs];
                  b_q     <= regs_q[rt];
                  alu_q   <= pc_q + (simm << 2);
                  state_q <= dec_d;
                end
        MEMADR: begin
                  alu_q   <= a_q + simm;
                  state_q <= op[3] ? MEMWR : MEMRD;
                end
        MEMRD:  if (iMemReady) begin
                  mdr_q   <= iMemRdata;
                  state_q <= MEMWB;
                end
        MEMWR:  if (iMemReady) state_q <= FETCH;
        EXEC:   begin
                  alu_q   <= alu_d;
                  state_q <= ALUWB;
                end
        ADDIEX: begin
                  alu_q   <= a_q + simm;
                  state_q <= ADDIWB;
                end
        BRANCH: begin
                  if (a_q == b_q) pc_q <= alu_q;
                  state_q <= FETCH;
                end
        JUMP:   begin
                  pc_q    <= {pc_q[31:28], ir_q[25:0], 2'b00};
                  state_q <= FETCH;
                end
        HALT:   state_q <= HALT;
        default: state_q <= FETCH;
      endcase
    end
endmodule

// File: tb/tb_mips_multicycle.sv
// tb_mips_multicycle: directed programs against a word memory model with programmable wait states.
module tb_mips_multicycle;
  logic clk = 0, rst = 1;
  logic req, we, rdy, ret, halt;
  logic [31:0] addr, wdata, rdata, pc;
  logic [3:0] st;
  logic j_req, j_we, j_halt, j_ret;
  logic [31:0] j_addr, j_wdata, j_pc, j_rdata;
  logic [3:0] j_st;
  logic [31:0] mem [1024];
  int waits = 0, wcnt = 0, cyc = 0, n_tests = 0, n_fail = 0, nreq;
  int retq[$];
  localparam logic [31:0] ILL = 32'hFC00_0000;
  localparam logic [31:0] JW  = {6'h02, 26'h40};

  mips_multicycle dut (
    .iClk(clk), .iReset(rst), .oMemReq(req), .oMemWe(we), .oMemAddr(addr), .oMemWdata(wdata),
    .iMemRdata(rdata), .iMemReady(rdy), .oPC(pc), .oState(st), .oHalt(halt), .oRetire(ret)
  );
  mips_multicycle #(.RESET_PC(32'h1000_0000)) u_j (
    .iClk(clk), .iReset(rst), .oMemReq(j_req), .oMemWe(j_we), .oMemAddr(j_addr), .oMemWdata(j_wdata),
    .iMemRdata(j_rdata), .iMemReady(1'b1), .oPC(j_pc), .oState(j_st), .oHalt(j_halt), .oRetire(j_ret)
  );

  always #5 clk = ~clk;
  assign rdata   = mem[addr[11:2]];
  assign rdy     = wcnt >= waits;
  assign j_rdata = j_addr == 32'h1000_0000 ? JW : ILL;

  always @(posedge clk) begin
    if (req && we && rdy) mem[addr[11:2]] = wdata;
    wcnt <= (req && !rdy) ? wcnt + 1 : 0;
    cyc  <= rst ? 0 : cyc + 1;
  end

  always @(negedge clk) begin
    #1;
    if (!rst && ret) retq.push_back(cyc + 1);
  end

  function automatic logic [31:0] itype(logic [5:0] op, int rs, int rt, int imm);
    return {op, rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] rtype(logic [5:0] fn, int rd, int rs, int rt);
    return {6'd0, rs[4:0], rt[4:0], rd[4:0], 5'd0, fn};
  endfunction

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    retq.delete();
    repeat (2) @(negedge clk);
    rst = 0;
  endtask

  task automatic check_retq(string tag, int exp[$]);
    check({tag, "_n"}, retq.size(), exp.size());
    for (int i = 0; i < exp.size() && i < retq.size(); i++)
      check($sformatf("%s_%0d", tag, i), retq[i], exp[i]);
  endtask

  bit es_req [11] = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 0};
  int es_st  [11] = '{0, 0, 0, 0, 1, 2, 3, 3, 3, 3, 4};

  initial begin
    clear_mem();
    repeat (2) @(negedge clk);
    #1;
    check("rst_req", req, 0);
    check("rst_we", we, 0);
    check("rst_halt", halt, 0);
    check("rst_ret", ret, 0);
    check("rst_pc", pc, 0);
    check("rst_state", st, 0);
    @(negedge clk);
    rst = 0;
    // Jump core: j 0x40 at 0x1000_0000 retires in cycle 3, fetches 0x1000_0100 in cycle 4.
    repeat (2) @(negedge clk);
    #1;
    check("j_ret", j_ret, 1);
    check("j_state", j_st, 11);
    @(negedge clk);
    #1;
    check("j_addr", j_addr, 32'h1000_0100);
    check("j_pc", j_pc, 32'h1000_0100);
    check("j_req", j_req, 1);
    check("j_we", j_we, 0);
    check("j_halt", j_halt, 0);

    // Basic program, zero-wait memory.
    clear_mem();
    mem[0] = itype(6'h08, 0, 1, 5);
    mem[1] = itype(6'h08, 0, 2, -3);
    mem[2] = rtype(6'h20, 3, 1, 2);
    mem[3] = itype(6'h2B, 0, 3, 8);
    mem[4] = itype(6'h23, 0, 4, 8);
    mem[5] = itype(6'h2B, 0, 4, 12);
    mem[6] = ILL;
    do_reset();
    repeat (35) @(negedge clk);
    #1;
    check("p1_mem8", mem[2], 2);
    check("p1_r4", mem[3], 2);
    check_retq("p1_ret", '{4, 8, 12, 16, 21, 25});
    check("p1_halt", halt, 1);
    check("p1_pc", pc, 32'h1C);

    // Three wait cycles on every access.
    clear_mem();
    mem[0]  = itype(6'h23, 0, 5, 32'h100);
    mem[1]  = itype(6'h2B, 0, 5, 32'h104);
    mem[2]  = ILL;
    mem[64] = 32'hDEAD_BEEF;
    waits = 3;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      #1;
      check($sformatf("w_req%0d", i + 1), req, es_req[i]);
      check($sformatf("w_st%0d", i + 1), st, es_st[i]);
      check($sformatf("w_ret%0d", i + 1), ret, i == 10);
      if (es_req[i]) check($sformatf("w_addr%0d", i + 1), addr, i < 4 ? 32'h0 : 32'h100);
      @(negedge clk);
    end
    repeat (29) @(negedge clk);
    check("w_r5", mem[65], 32'hDEAD_BEEF);
    check_retq("w_ret", '{11, 21});

    // Reset in the middle of a read access.
    do_reset();
    repeat (7) @(negedge clk);
    #1;
    check("mid_st", st, 3);
    check("mid_req", req, 1);
    rst = 1;
    #1;
    check("mid_rst_req", req, 0);
    check("mid_rst_pc", pc, 0);
    check("mid_rst_halt", halt, 0);
    check("mid_rst_ret", ret, 0);
    check("mid_rst_st", st, 0);
    waits = 0;

    // beq taken and not taken.
    for (int t = 0; t < 2; t++) begin
      clear_mem();
      mem[0] = itype(6'h08, 0, 1, 7);
      mem[1] = itype(6'h08, 0, 2, t == 0 ? 7 : 8);
      mem[2] = itype(6'h08, 0, 3, 0);
      mem[3] = itype(6'h08, 0, 3, 0);
      mem[4] = itype(6'h04, 1, 2, 2);
      mem[5] = ILL;
      mem[6] = ILL;
      mem[7] = ILL;
      do_reset();
      repeat (30) @(negedge clk);
      #1;
      check($sformatf("beq%0d_pc", t), pc, t == 0 ? 32'h20 : 32'h18);
      check_retq($sformatf("beq%0d_ret", t), '{4, 8, 12, 16, 19});
    end

    // Writes to $0 are discarded.
    clear_mem();
    mem[0]  = itype(6'h08, 0, 0, 9);
    mem[1]  = itype(6'h2B, 0, 0, 32'h80);
    mem[2]  = ILL;
    mem[32] = 32'h55;
    do_reset();
    repeat (20) @(negedge clk);
    check("r0", mem[32], 0);

    // ALU ops: slt, sub, or, and, add wrap; ends on an unsupported funct.
    clear_mem();
    mem[0]  = itype(6'h08, 0, 1, -1);
    mem[1]  = itype(6'h08, 0, 2, 1);
    mem[2]  = rtype(6'h2A, 3, 1, 2);
    mem[3]  = itype(6'h2B, 0, 3, 32'h80);
    mem[4]  = rtype(6'h2A, 3, 2, 1);
    mem[5]  = itype(6'h2B, 0, 3, 32'h84);
    mem[6]  = itype(6'h23, 0, 4, 32'h100);
    mem[7]  = rtype(6'h22, 6, 4, 2);
    mem[8]  = itype(6'h2B, 0, 6, 32'h88);
    mem[9]  = rtype(6'h25, 7, 4, 2);
    mem[10] = itype(6'h2B, 0, 7, 32'h8C);
    mem[11] = rtype(6'h24, 8, 1, 4);
    mem[12] = itype(6'h2B, 0, 8, 32'h90);
    mem[13] = rtype(6'h20, 9, 4, 4);
    mem[14] = itype(6'h2B, 0, 9, 32'h94);
    mem[15] = 32'h0;
    mem[32] = 32'h55;
    mem[33] = 32'h55;
    mem[37] = 32'h77;
    mem[64] = 32'h8000_0000;
    do_reset();
    repeat (80) @(negedge clk);
    #1;
    check("slt_lt", mem[32], 1);
    check("slt_ge", mem[33], 0);
    check("sub", mem[34], 32'h7FFF_FFFF);
    check("or", mem[35], 32'h8000_0001);
    check("and", mem[36], 32'h8000_0000);
    check("add_wrap", mem[37], 0);
    check("funct_halt", halt, 1);
    check("funct_pc", pc, 32'h40);

    // Illegal opcode at 0x8.
    clear_mem();
    mem[0] = itype(6'h08, 0, 1, 1);
    mem[1] = itype(6'h08, 0, 2, 2);
    mem[2] = ILL;
    do_reset();
    repeat (11) @(negedge clk);
    #1;
    check("ill_halt", halt, 1);
    check("ill_pc", pc, 32'hC);
    check("ill_st", st, 12);
    nreq = 0;
    repeat (10) begin
      @(negedge clk);
      #1;
      if (req) nreq++;
    end
    check("ill_noreq", nreq, 0);
    check_retq("ill_ret", '{4, 8});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
